// File: rtl/rr_stream_arbiter.sv
// Round-robin packet arbiter for N ready/valid streams sharing one mux output.
// A stream holds the grant for a whole packet. A per-packet beat watchdog
// locks out streams that never send an end-of-packet beat. Each input has a
// saturating counter of completed packets.

module rr_stream_arbiter #(
  parameter int P_NUM_INPUTS = 4,
  parameter int P_MAX_BEATS  = 1024,
  parameter int P_CNT_WIDTH  = 16
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic [P_NUM_INPUTS-1:0]               valid_in,
  input  logic [P_NUM_INPUTS-1:0]               last_in,
  input  logic                                  ready_out,
  input  logic [P_NUM_INPUTS-1:0]               enable_mask,
  input  logic [P_NUM_INPUTS-1:0]               clear_err,
  output logic [P_NUM_INPUTS-1:0]               grant,
  output logic [$clog2(P_NUM_INPUTS)-1:0]       sel,
  output logic                                  active,
  output logic [P_NUM_INPUTS-1:0]               err_mask,
  output logic                                  timeout_err,
  output logic [P_NUM_INPUTS*P_CNT_WIDTH-1:0]   pkt_count
);

  localparam int SW = $clog2(P_NUM_INPUTS);
  localparam int BW = (P_MAX_BEATS > 1) ? $clog2(P_MAX_BEATS) : 1;
  localparam logic [BW-1:0] LAST_BEAT = BW'(P_MAX_BEATS - 1);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  state_t                    r_state;
  logic [P_NUM_INPUTS-1:0]   r_grant;
  logic [SW-1:0]             r_sel;
  logic                      r_active;
  logic [SW-1:0]             r_rrPtr;
  logic [BW-1:0]             r_beatCnt;
  logic [P_NUM_INPUTS-1:0]   r_errMask;
  logic                      r_timeoutErr;
  logic [P_CNT_WIDTH-1:0]    r_pktCount [P_NUM_INPUTS];

  logic [P_NUM_INPUTS-1:0]   w_eligible;
  logic                      w_pickValid;
  logic [SW-1:0]             w_pickIdx;
  logic                      w_beatAccept;

  assign w_eligible   = valid_in & enable_mask & ~r_errMask;
  assign w_beatAccept = (r_state == ST_BUSY) && valid_in[r_sel] && ready_out;

  // Find the first eligible input strictly after the last winner, wrapping around.
  // Scanning from the far end lets the nearest candidate overwrite the others.
  always_comb begin
    w_pickValid = 1'b0;
    w_pickIdx   = '0;
    for (int k = P_NUM_INPUTS; k >= 1; k--) begin
      if (w_eligible[SW'((int'(r_rrPtr) + k) % P_NUM_INPUTS)]) begin
        w_pickValid = 1'b1;
        w_pickIdx   = SW'((int'(r_rrPtr) + k) % P_NUM_INPUTS);
      end
    end
  end

  // Arbitration FSM: every output is registered, so no input reaches grant/sel/active combinationally.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_grant      <= '0;
      r_sel        <= '0;
      r_active     <= 1'b0;
      r_rrPtr      <= SW'(P_NUM_INPUTS - 1);
      r_beatCnt    <= '0;
      r_errMask    <= '0;
      r_timeoutErr <= 1'b0;
      for (int i = 0; i < P_NUM_INPUTS; i++) begin
        r_pktCount[i] <= '0;
      end
    end else begin
      r_timeoutErr <= 1'b0;
      r_errMask    <= r_errMask & ~clear_err;
      case (r_state)
        ST_IDLE: begin
          if (w_pickValid) begin
            r_state   <= ST_BUSY;
            r_active  <= 1'b1;
            r_grant   <= P_NUM_INPUTS'(1) << w_pickIdx;
            r_sel     <= w_pickIdx;
            r_rrPtr   <= w_pickIdx;
            r_beatCnt <= '0;
          end
        end
        ST_BUSY: begin
          if (w_beatAccept) begin
            r_beatCnt <= r_beatCnt + BW'(1);
            if (last_in[r_sel]) begin
              r_state  <= ST_IDLE;
              r_active <= 1'b0;
              r_grant  <= '0;
              if (r_pktCount[r_sel] != '1) begin
                r_pktCount[r_sel] <= r_pktCount[r_sel] + P_CNT_WIDTH'(1);
              end
            end else if (r_beatCnt == LAST_BEAT) begin
              r_state      <= ST_IDLE;
              r_active     <= 1'b0;
              r_grant      <= '0;
              r_timeoutErr <= 1'b1;
              r_errMask    <= (r_errMask & ~clear_err) | r_grant;
            end
          end
        end
        default: begin
          r_state  <= ST_IDLE;
          r_active <= 1'b0;
          r_grant  <= '0;
        end
      endcase
    end
  end

  assign grant       = r_grant;
  assign sel         = r_sel;
  assign active      = r_active;
  assign err_mask    = r_errMask;
  assign timeout_err = r_timeoutErr;

  for (genvar g = 0; g < P_NUM_INPUTS; g++) begin : g_pktOut
    assign pkt_count[g*P_CNT_WIDTH +: P_CNT_WIDTH] = r_pktCount[g];
  end

endmodule

// File: tb/tb_rr_stream_arbiter.sv
// Directed bench for rr_stream_arbiter: round-robin order, masking, watchdog
// lockout, backpressure, counter saturation and mid-packet reset.

module tb_rr_stream_arbiter;

  localparam int N  = 4;
  localparam int MB = 8;
  localparam int CW = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic [N-1:0]      valid_in;
  logic [N-1:0]      last_in;
  logic              ready_out;
  logic [N-1:0]      enable_mask;
  logic [N-1:0]      clear_err;
  logic [N-1:0]      grant;
  logic [1:0]        sel;
  logic              active;
  logic [N-1:0]      err_mask;
  logic              timeout_err;
  logic [N*CW-1:0]   pkt_count;

  int testsRun   = 0;
  int testsFailed = 0;

  rr_stream_arbiter #(
    .P_NUM_INPUTS (N),
    .P_MAX_BEATS  (MB),
    .P_CNT_WIDTH  (CW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .valid_in    (valid_in),
    .last_in     (last_in),
    .ready_out   (ready_out),
    .enable_mask (enable_mask),
    .clear_err   (clear_err),
    .grant       (grant),
    .sel         (sel),
    .active      (active),
    .err_mask    (err_mask),
    .timeout_err (timeout_err),
    .pkt_count   (pkt_count)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  // Hard stop in case the sequence ever stalls.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [CW-1:0] pktOf(input int idx);
    return pkt_count[idx*CW +: CW];
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    testsRun++;
    assert (observed === expected) else begin
      testsFailed++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Drive inputs, let one rising edge pass, then settle 1 time unit past it.
  task automatic applyStimulus(input logic [N-1:0] v, input logic [N-1:0] l, input logic r,
                               input logic [N-1:0] en, input logic [N-1:0] clr);
    valid_in    = v;
    last_in     = l;
    ready_out   = r;
    enable_mask = en;
    clear_err   = clr;
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    rst = 1'b1;
    applyStimulus('0, '0, 1'b0, '0, '0);
    applyStimulus('0, '0, 1'b0, '0, '0);
    rst = 1'b0;
  endtask

  // One arbitration edge followed by a two-beat packet; the arbiter ends up back in IDLE.
  task automatic runPacket2(input int expIdx, input logic [N-1:0] v, input logic [N-1:0] en);
    applyStimulus(v, 4'b0000, 1'b1, en, 4'b0000);
    checkOutput($sformatf("grant_pkt%0d", expIdx), {28'b0, grant}, 32'(1) << expIdx);
    checkOutput($sformatf("sel_pkt%0d", expIdx), {30'b0, sel}, 32'(expIdx));
    checkOutput($sformatf("active_pkt%0d", expIdx), {31'b0, active}, 32'd1);
    applyStimulus(v, 4'b0000, 1'b1, en, 4'b0000);
    checkOutput("active_beat1", {31'b0, active}, 32'd1);
    applyStimulus(v, 4'b1111, 1'b1, en, 4'b0000);
    checkOutput("active_end", {31'b0, active}, 32'd0);
    checkOutput("grant_end", {28'b0, grant}, 32'd0);
    checkOutput("sel_hold", {30'b0, sel}, 32'(expIdx));
  endtask

  initial begin
    rst = 1'b0;
    valid_in = '0; last_in = '0; ready_out = 1'b0; enable_mask = '0; clear_err = '0;

    // Reset state.
    doReset();
    checkOutput("rst_active", {31'b0, active}, 32'd0);
    checkOutput("rst_grant", {28'b0, grant}, 32'd0);
    checkOutput("rst_sel", {30'b0, sel}, 32'd0);
    checkOutput("rst_err", {28'b0, err_mask}, 32'd0);
    checkOutput("rst_tmo", {31'b0, timeout_err}, 32'd0);
    checkOutput("rst_pkt", {24'b0, pkt_count}, 32'd0);

    // All inputs requesting: strict rotation 0,1,2,3,0.
    runPacket2(0, 4'b1111, 4'b1111);
    runPacket2(1, 4'b1111, 4'b1111);
    runPacket2(2, 4'b1111, 4'b1111);
    runPacket2(3, 4'b1111, 4'b1111);
    checkOutput("round_pkt", {24'b0, pkt_count}, 32'h55);
    runPacket2(0, 4'b1111, 4'b1111);
    checkOutput("round_pkt0", {30'b0, pktOf(0)}, 32'd2);

    // Input 2 disabled: order 0,1,3,0.
    doReset();
    runPacket2(0, 4'b1111, 4'b1011);
    runPacket2(1, 4'b1111, 4'b1011);
    runPacket2(3, 4'b1111, 4'b1011);
    runPacket2(0, 4'b1111, 4'b1011);
    checkOutput("mask_pkt2", {30'b0, pktOf(2)}, 32'd0);

    // Watchdog: input 1 streams 8 beats without last.
    doReset();
    applyStimulus(4'b0010, 4'b0000, 1'b1, 4'b1111, 4'b0000);
    checkOutput("wd_grant", {28'b0, grant}, 32'h2);
    for (int b = 0; b < 7; b++) applyStimulus(4'b0010, 4'b0000, 1'b1, 4'b1111, 4'b0000);
    checkOutput("wd_busy7", {31'b0, active}, 32'd1);
    checkOutput("wd_notmo7", {31'b0, timeout_err}, 32'd0);
    applyStimulus(4'b0010, 4'b0000, 1'b1, 4'b1111, 4'b0000);
    checkOutput("wd_pulse", {31'b0, timeout_err}, 32'd1);
    checkOutput("wd_errmask", {28'b0, err_mask}, 32'h2);
    checkOutput("wd_idle", {31'b0, active}, 32'd0);
    checkOutput("wd_pkt1", {30'b0, pktOf(1)}, 32'd0);
    applyStimulus(4'b0010, 4'b0000, 1'b1, 4'b1111, 4'b0000);
    checkOutput("wd_pulse_end", {31'b0, timeout_err}, 32'd0);
    applyStimulus(4'b0010, 4'b0000, 1'b1, 4'b1111, 4'b0000);
    applyStimulus(4'b0010, 4'b0000, 1'b1, 4'b1111, 4'b0000);
    checkOutput("wd_locked", {31'b0, active}, 32'd0);
    applyStimulus(4'b0010, 4'b0000, 1'b1, 4'b1111, 4'b0010);
    checkOutput("wd_cleared", {28'b0, err_mask}, 32'h0);
    checkOutput("wd_clr_nogrant", {31'b0, active}, 32'd0);
    applyStimulus(4'b0010, 4'b0000, 1'b1, 4'b1111, 4'b0000);
    checkOutput("wd_regrant", {28'b0, grant}, 32'h2);
    applyStimulus(4'b0010, 4'b0010, 1'b1, 4'b1111, 4'b0000);
    checkOutput("wd_pkt1_done", {30'b0, pktOf(1)}, 32'd1);

    // Backpressure: ready 1,0,0,1 then last beat on input 2.
    doReset();
    applyStimulus(4'b0100, 4'b0000, 1'b1, 4'b1111, 4'b0000);
    checkOutput("bp_grant", {28'b0, grant}, 32'h4);
    applyStimulus(4'b0100, 4'b0000, 1'b1, 4'b1111, 4'b0000);
    applyStimulus(4'b0100, 4'b0100, 1'b0, 4'b1111, 4'b0000);
    checkOutput("bp_hold1", {28'b0, grant}, 32'h4);
    applyStimulus(4'b0100, 4'b0100, 1'b0, 4'b0000, 4'b0000);
    checkOutput("bp_hold2", {28'b0, grant}, 32'h4);
    applyStimulus(4'b0100, 4'b0000, 1'b1, 4'b1111, 4'b0000);
    checkOutput("bp_beat2", {31'b0, active}, 32'd1);
    applyStimulus(4'b0100, 4'b0100, 1'b1, 4'b1111, 4'b0000);
    checkOutput("bp_end", {31'b0, active}, 32'd0);
    checkOutput("bp_pkt2", {30'b0, pktOf(2)}, 32'd1);

    // Saturation on a 2-bit counter, then reset in the middle of a packet.
    doReset();
    for (int p = 0; p < 5; p++) begin
      applyStimulus(4'b0001, 4'b0001, 1'b1, 4'b1111, 4'b0000);
      applyStimulus(4'b0001, 4'b0001, 1'b1, 4'b1111, 4'b0000);
      if (p == 2) checkOutput("sat_pkt0_3", {30'b0, pktOf(0)}, 32'd3);
    end
    checkOutput("sat_pkt0", {30'b0, pktOf(0)}, 32'd3);
    applyStimulus(4'b0001, 4'b0000, 1'b1, 4'b1111, 4'b0000);
    applyStimulus(4'b0001, 4'b0000, 1'b1, 4'b1111, 4'b0000);
    checkOutput("mid_active", {31'b0, active}, 32'd1);
    rst = 1'b1;
    applyStimulus(4'b1111, 4'b1111, 1'b1, 4'b1111, 4'b0000);
    rst = 1'b0;
    checkOutput("mid_rst_active", {31'b0, active}, 32'd0);
    checkOutput("mid_rst_grant", {28'b0, grant}, 32'd0);
    checkOutput("mid_rst_pkt", {24'b0, pkt_count}, 32'd0);
    checkOutput("mid_rst_tmo", {31'b0, timeout_err}, 32'd0);
    applyStimulus(4'b1111, 4'b0000, 1'b1, 4'b1111, 4'b0000);
    checkOutput("mid_rst_first", {28'b0, grant}, 32'h1);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
